// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer
//   Queues operand/opcode commands from an upstream valid/ready source and
//   issues them one at a time to an ALU that uses a start/busy/done
//   handshake. Operands are held stable for the whole operation. Result and
//   flags are captured on done, or a timeout response is forced if done never
//   arrives. Each response is offered downstream on a valid/ready port.
//
// Ports
//   clk, rst_n                     clock, async active-low reset
//   cmd_valid/cmd_ready            upstream command handshake
//   cmd_a, cmd_b, cmd_opcode       command payload
//   alu_start                      one-cycle start pulse to the ALU
//   alu_A, alu_B, alu_opcode       operands held for the ALU
//   alu_result, alu_Z/N/C/V        ALU registered result and flags
//   alu_busy, alu_done             ALU status
//   rsp_valid/rsp_ready            downstream response handshake
//   rsp_result, rsp_flags          captured result and flags {Z,N,C,V}
//   rsp_timeout                    response was forced by timeout
//   fifo_count                     command FIFO occupancy
module alu_cmd_issuer #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 3,
  parameter int TIMEOUT    = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [7:0]       cmd_a,
  input  logic [7:0]       cmd_b,
  input  logic [3:0]       cmd_opcode,
  output logic             alu_start,
  output logic [7:0]       alu_A,
  output logic [7:0]       alu_B,
  output logic [3:0]       alu_opcode,
  input  logic [7:0]       alu_result,
  input  logic             alu_Z,
  input  logic             alu_N,
  input  logic             alu_C,
  input  logic             alu_V,
  input  logic             alu_busy,
  input  logic             alu_done,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_result,
  output logic [3:0]       rsp_flags,
  output logic             rsp_timeout,
  output logic [CNT_W-1:0] fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int TMO_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] op;
  } cmd_t;

  // ---------------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------------
  cmd_t             r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  state_t           r_state;

  logic w_push;
  logic w_pop;
  cmd_t w_head;

  // Ready comes from the registered count only, so a same-cycle pop never
  // opens a slot while full.
  assign cmd_ready = (r_count != FULL_CNT);
  assign w_push    = cmd_valid && cmd_ready;
  // A done or busy left over from before a reset blocks issue until it clears.
  assign w_pop     = (r_state == S_IDLE) && (r_count != '0) && !alu_busy && !alu_done;
  assign w_head    = r_mem[r_rd_ptr];
  assign fifo_count = r_count;

  // NOTE: storage has no reset; entries are only read when the count says
  // they were written, so clearing them would buy nothing.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {cmd_a, cmd_b, cmd_opcode};
  end

  // NOTE: non-blocking assignments for all state so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Issue FSM with registered outputs
  // ---------------------------------------------------------------------------
  logic             r_alu_start;
  logic [7:0]       r_alu_a;
  logic [7:0]       r_alu_b;
  logic [3:0]       r_alu_op;
  logic             r_rsp_valid;
  logic [7:0]       r_rsp_result;
  logic [3:0]       r_rsp_flags;
  logic             r_rsp_timeout;
  logic [TMO_W-1:0] r_tmo_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_alu_start   <= 1'b0;
      r_alu_a       <= '0;
      r_alu_b       <= '0;
      r_alu_op      <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_result  <= '0;
      r_rsp_flags   <= '0;
      r_rsp_timeout <= 1'b0;
      r_tmo_cnt     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_alu_a     <= w_head.a;
            r_alu_b     <= w_head.b;
            r_alu_op    <= w_head.op;
            r_alu_start <= 1'b1;
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_alu_start <= 1'b0;
          r_tmo_cnt   <= '0;
          r_state     <= S_WAIT;
        end
        S_WAIT: begin
          if (alu_done) begin
            r_rsp_result  <= alu_result;
            r_rsp_flags   <= {alu_Z, alu_N, alu_C, alu_V};
            r_rsp_timeout <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_state       <= S_RESP;
          end else if (r_tmo_cnt == TMO_LAST) begin
            // Counter started at 0 on the first WAIT cycle, so this is the
            // TIMEOUT-th WAIT cycle without done.
            r_rsp_result  <= '0;
            r_rsp_flags   <= '0;
            r_rsp_timeout <= 1'b1;
            r_rsp_valid   <= 1'b1;
            r_state       <= S_RESP;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign alu_start   = r_alu_start;
  assign alu_A       = r_alu_a;
  assign alu_B       = r_alu_b;
  assign alu_opcode  = r_alu_op;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_result  = r_rsp_result;
  assign rsp_flags   = r_rsp_flags;
  assign rsp_timeout = r_rsp_timeout;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Testbench for alu_cmd_issuer: a small ALU model drives the handshake,
// expected responses come from plain-integer arithmetic kept in a queue.
module tb_alu_cmd_issuer;

  localparam int FIFO_DEPTH = 4;
  localparam int CNT_W      = 3;
  localparam int TIMEOUT    = 15;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [7:0]       cmd_a = '0;
  logic [7:0]       cmd_b = '0;
  logic [3:0]       cmd_opcode = '0;
  logic             alu_start;
  logic [7:0]       alu_A;
  logic [7:0]       alu_B;
  logic [3:0]       alu_opcode;
  logic [7:0]       alu_result;
  logic             alu_Z, alu_N, alu_C, alu_V;
  logic             alu_busy;
  logic             alu_done;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [7:0]       rsp_result;
  logic [3:0]       rsp_flags;
  logic             rsp_timeout;
  logic [CNT_W-1:0] fifo_count;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    logic [7:0] res;
    logic [3:0] flags;
    logic       to;
  } rsp_t;

  rsp_t exp_q[$];

  logic hang       = 1'b0;  // ALU model abandons the op without done
  logic stray_done = 1'b0;  // extra done pulses injected by the bench

  always #5 clk = ~clk;

  alu_cmd_issuer #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .CNT_W     (CNT_W),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_opcode (cmd_opcode),
    .alu_start  (alu_start),
    .alu_A      (alu_A),
    .alu_B      (alu_B),
    .alu_opcode (alu_opcode),
    .alu_result (alu_result),
    .alu_Z      (alu_Z),
    .alu_N      (alu_N),
    .alu_C      (alu_C),
    .alu_V      (alu_V),
    .alu_busy   (alu_busy),
    .alu_done   (alu_done),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_flags  (rsp_flags),
    .rsp_timeout(rsp_timeout),
    .fifo_count (fifo_count)
  );

  // ---------------------------------------------------------------------------
  // ALU model: IDLE -> EXEC -> DONE, no reset
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {M_IDLE, M_EXEC, M_DONE} mst_t;
  mst_t       m_st    = M_IDLE;
  logic [7:0] m_res   = '0;
  logic [3:0] m_flags = '0;

  function automatic logic [11:0] alu_add(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] w;
    w = {1'b0, a} + {1'b0, b};
    return {w[7:0] == 8'h00, w[7], w[8], (a[7] == b[7]) && (w[7] != a[7]), w[7:0]};
  endfunction

  always @(posedge clk) begin
    case (m_st)
      M_IDLE: if (alu_start) m_st <= M_EXEC;
      M_EXEC: begin
        if (hang) begin
          m_st <= M_IDLE;
        end else begin
          {m_flags, m_res} <= alu_add(alu_A, alu_B);
          m_st <= M_DONE;
        end
      end
      default: m_st <= M_IDLE;
    endcase
  end

  assign alu_busy   = (m_st == M_EXEC);
  assign alu_done   = (m_st == M_DONE) || stray_done;
  assign alu_result = m_res;
  assign {alu_Z, alu_N, alu_C, alu_V} = m_flags;

  // ---------------------------------------------------------------------------
  // Reference: integer arithmetic for opcode 0
  // ---------------------------------------------------------------------------
  function automatic rsp_t ref_add(input int a, input int b);
    rsp_t r;
    int s, sa, sb, sv;
    s  = a + b;
    sa = (a > 127) ? a - 256 : a;
    sb = (b > 127) ? b - 256 : b;
    sv = sa + sb;
    r.res   = 8'(s % 256);
    r.flags = {(s % 256) == 0, (s % 256) >= 128, s > 255, (sv > 127) || (sv < -128)};
    r.to    = 1'b0;
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offers one command and returns on the falling edge after it is accepted.
  task automatic push_cmd(input logic [7:0] a, input logic [7:0] b, input bit track);
    int w;
    w = 0;
    cmd_valid = 1'b1;
    cmd_a = a;
    cmd_b = b;
    cmd_opcode = 4'h0;
    while (!cmd_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("push_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    if (track) begin
      if (hang) exp_q.push_back('{res: 8'h00, flags: 4'h0, to: 1'b1});
      else      exp_q.push_back(ref_add(int'(a), int'(b)));
    end
  endtask

  task automatic wait_rsp(output int cyc);
    cyc = 0;
    while (!rsp_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // Accepts one response and compares it against the head of the queue.
  task automatic expect_rsp(input string tag, output int cyc);
    rsp_t e;
    rsp_ready = 1'b1;
    wait_rsp(cyc);
    check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, "_queued"}, 32'(exp_q.size() > 0), 32'd1);
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else                  e = '{res: 8'h00, flags: 4'h0, to: 1'b0};
    check({tag, "_result"},  32'(rsp_result),  32'(e.res));
    check({tag, "_flags"},   32'(rsp_flags),   32'(e.flags));
    check({tag, "_timeout"}, 32'(rsp_timeout), 32'(e.to));
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, "_drop"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [7:0] fa [6];
  logic [7:0] fb [6];
  int cyc, acc, w, quiet, n;
  rsp_t r0;

  initial begin
    // ---- reset state ----
    repeat (2) @(negedge clk);
    check("rst_count",    32'(fifo_count),  32'd0);
    check("rst_ready",    32'(cmd_ready),   32'd1);
    check("rst_start",    32'(alu_start),   32'd0);
    check("rst_A",        32'(alu_A),       32'd0);
    check("rst_B",        32'(alu_B),       32'd0);
    check("rst_op",       32'(alu_opcode),  32'd0);
    check("rst_rvalid",   32'(rsp_valid),   32'd0);
    check("rst_rresult",  32'(rsp_result),  32'd0);
    check("rst_rflags",   32'(rsp_flags),   32'd0);
    check("rst_rtimeout", 32'(rsp_timeout), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // ---- single op, cycle-exact latency ----
    cmd_valid = 1'b1; cmd_a = 8'h05; cmd_b = 8'h03; cmd_opcode = 4'h0;
    @(negedge clk);                           // E0 accepted
    cmd_valid = 1'b0;
    exp_q.push_back(ref_add(5, 3));
    check("s_count_e0", 32'(fifo_count), 32'd1);
    check("s_start_e0", 32'(alu_start),  32'd0);
    @(negedge clk);                           // after E1: ISSUE
    check("s_start_e1", 32'(alu_start),  32'd1);
    check("s_A_e1",     32'(alu_A),      32'h05);
    check("s_B_e1",     32'(alu_B),      32'h03);
    check("s_count_e1", 32'(fifo_count), 32'd0);
    @(negedge clk);                           // after E2: WAIT
    check("s_start_e2", 32'(alu_start),  32'd0);
    @(negedge clk);                           // after E3: ALU done
    check("s_valid_e3", 32'(rsp_valid),  32'd0);
    @(negedge clk);                           // after E4: RESP
    check("s_valid_e4", 32'(rsp_valid),  32'd1);
    expect_rsp("single", cyc);

    // ---- flag cases ----
    push_cmd(8'hFF, 8'h01, 1'b1);
    expect_rsp("zc", cyc);
    check("zc_latency", 32'(cyc), 32'd4);
    push_cmd(8'h7F, 8'h01, 1'b1);
    expect_rsp("nv", cyc);

    // ---- FIFO full under response backpressure ----
    rsp_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      fa[i] = 8'($urandom_range(0, 255));
      fb[i] = 8'($urandom_range(0, 255));
      cmd_valid = 1'b1; cmd_a = fa[i]; cmd_b = fb[i]; cmd_opcode = 4'h0;
      w = 0;
      while (!cmd_ready && w < 12) begin
        @(negedge clk);
        w++;
      end
      if (cmd_ready) begin
        acc++;
        exp_q.push_back(ref_add(int'(fa[i]), int'(fb[i])));
        @(negedge clk);
      end
    end
    cmd_valid = 1'b0;
    check("full_accepted", 32'(acc),        32'd5);
    check("full_count",    32'(fifo_count), 32'd4);
    check("full_ready",    32'(cmd_ready),  32'd0);
    check("full_rvalid",   32'(rsp_valid),  32'd1);
    r0 = exp_q[0];
    repeat (3) @(negedge clk);
    check("hold_A",      32'(alu_A),      32'(fa[0]));
    check("hold_B",      32'(alu_B),      32'(fb[0]));
    check("hold_result", 32'(rsp_result), 32'(r0.res));
    check("hold_flags",  32'(rsp_flags),  32'(r0.flags));
    for (int i = 0; i < 5; i++) begin
      expect_rsp("full", cyc);
      if (i > 0) check("full_throughput", 32'(cyc), 32'd4);
    end

    // ---- timeout, then a normal op ----
    hang = 1'b1;
    push_cmd(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b1);
    expect_rsp("tmo", cyc);
    check("tmo_latency", 32'(cyc), 32'(TIMEOUT + 2));
    hang = 1'b0;
    push_cmd(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b1);
    expect_rsp("post_tmo", cyc);
    check("post_tmo_latency", 32'(cyc), 32'd4);

    // ---- reset during WAIT, released while the ALU is in DONE ----
    push_cmd(8'h11, 8'h22, 1'b0);
    @(negedge clk);                           // ISSUE
    @(negedge clk);                           // WAIT, ALU in EXEC
    rst_n = 1'b0;
    @(negedge clk);                           // ALU now in DONE
    rst_n = 1'b1;
    check("mid_rst_count",  32'(fifo_count), 32'd0);
    check("mid_rst_rvalid", 32'(rsp_valid),  32'd0);
    check("mid_rst_A",      32'(alu_A),      32'd0);
    quiet = 0;
    repeat (6) begin
      if (rsp_valid || alu_start) quiet++;
      @(negedge clk);
    end
    check("mid_rst_quiet", 32'(quiet), 32'd0);
    push_cmd(8'h40, 8'h41, 1'b1);
    expect_rsp("post_rst", cyc);

    // ---- stray done: ignored when empty, blocks issue when not ----
    stray_done = 1'b1;
    repeat (2) @(negedge clk);
    stray_done = 1'b0;
    quiet = 0;
    repeat (5) begin
      if (rsp_valid || alu_start) quiet++;
      @(negedge clk);
    end
    check("stray_quiet", 32'(quiet), 32'd0);
    stray_done = 1'b1;
    push_cmd(8'h20, 8'hE0, 1'b1);
    repeat (3) @(negedge clk);
    check("stray_block_count", 32'(fifo_count), 32'd1);
    check("stray_block_start", 32'(alu_start),  32'd0);
    stray_done = 1'b0;
    expect_rsp("stray_after", cyc);

    // ---- random bursts ----
    repeat (3) begin
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++)
        push_cmd(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b1);
      for (int i = 0; i < n; i++) expect_rsp("rand", cyc);
    end

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("end_count",   32'(fifo_count),   32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
